rv_load_writeback: RTL and testbench

- Load execution and register-file writeback unit for the RISC-V core.
- Accepts one load command at a time from the execute stage and issues a word read to data memory over a req/gnt/rvalid handshake.
- Extracts and sign- or zero-extends the addressed byte, halfword or word.
- Drives the register file's single write port, merging single-cycle ALU writebacks with the multi-cycle load result.

---
 rtl/rv_load_writeback.sv | 150 +++++++++++++++
 tb/tb_rv_load_writeback.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_load_writeback.sv
// Load unit with register-file writeback: issues one aligned word read, extracts
// and extends the addressed lane, and shares the write port with the ALU.
module rv_load_writeback #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_funct3_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        alu_wb_valid_i,
    input  logic [4:0]  alu_wb_rd_i,
    input  logic [31:0] alu_wb_data_i,
    output logic        reg_write_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] write_data_o,
    output logic        busy_o,
    output logic [4:0]  pend_rd_o,
    output logic        ld_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        cmd_bad;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ld_ext;
    logic        alu_sel;
    logic        ld_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            rd_q     <= 5'd0;
            funct3_q <= 3'd0;
            cnt_q    <= 16'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        case (ld_funct3_i)
            3'b000, 3'b100: cmd_bad = 1'b0;
            3'b001, 3'b101: cmd_bad = ld_addr_i[0];
            3'b010:         cmd_bad = (ld_addr_i[1:0] != 2'b00);
            default:        cmd_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata_i[7:0];
            2'd1:    byte_lane = mem_rdata_i[15:8];
            2'd2:    byte_lane = mem_rdata_i[23:16];
            default: byte_lane = mem_rdata_i[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  ld_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  ld_ext = {24'd0, byte_lane};
            3'b101:  ld_ext = {16'd0, half_lane};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    // ALU owns the port whenever it writes a real register; x0 writes free it.
    assign alu_sel = alu_wb_valid_i && (alu_wb_rd_i != 5'd0);
    assign ld_sel  = !rst && (state_q == S_WB) && (rd_q != 5'd0) && !alu_sel;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_valid_i) begin
                    addr_d   = ld_addr_i;
                    rd_d     = ld_rd_i;
                    funct3_d = ld_funct3_i;
                    if (cmd_bad) err_d = 1'b1;
                    else         state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    data_d  = ld_ext;
                    state_d = S_WB;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                // A load to x0 never needs the port, so it retires regardless.
                if ((rd_q == 5'd0) || !alu_sel) state_d = S_IDLE;
            end
        endcase
    end

    assign ld_ready_o   = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign pend_rd_o    = busy_o ? rd_q : 5'd0;
    assign ld_err_o     = err_q;
    assign reg_write_o  = alu_sel || ld_sel;
    assign write_reg_o  = alu_sel ? alu_wb_rd_i : rd_q;
    assign write_data_o = alu_sel ? alu_wb_data_i : data_q;

endmodule

// File: tb/tb_rv_load_writeback.sv
// Directed bench for rv_load_writeback; every register-file write is checked
// against a queue of expected {rd, data} entries.
module tb_rv_load_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [31:0] ld_addr_i;
  logic [4:0]  ld_rd_i;
  logic [2:0]  ld_funct3_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        alu_wb_valid_i;
  logic [4:0]  alu_wb_rd_i;
  logic [31:0] alu_wb_data_i;
  logic        reg_write_o;
  logic [4:0]  write_reg_o;
  logic [31:0] write_data_o;
  logic        busy_o;
  logic [4:0]  pend_rd_o;
  logic        ld_err_o;

  int n_assert = 0;
  int n_fail = 0;
  int n_txn = 0;
  int n_req_cyc = 0;
  logic [36:0] exp_q[$];

  rv_load_writeback #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
    .ld_rd_i(ld_rd_i), .ld_funct3_i(ld_funct3_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_rd_i(alu_wb_rd_i), .alu_wb_data_i(alu_wb_data_i),
    .reg_write_o(reg_write_o), .write_reg_o(write_reg_o), .write_data_o(write_data_o),
    .busy_o(busy_o), .pend_rd_o(pend_rd_o), .ld_err_o(ld_err_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every write pops the queue; memory handshakes are counted
  always @(negedge clk) begin
    if (mem_req_o === 1'b1) n_req_cyc++;
    if ((mem_req_o === 1'b1) && (mem_gnt_i === 1'b1)) n_txn++;
    if (reg_write_o !== 1'b0) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed=x%0d=%0h expected=no_write", write_reg_o, write_data_o);
      end
      if (exp_q.size() != 0) chk("wb_data", {27'd0, write_reg_o, write_data_o}, {27'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                         input int alu_n, input logic [31:0] exp_data);
    int txn0;
    logic [31:0] wa;
    txn0 = n_txn;
    wa = {a[31:2], 2'b00};
    ld_valid_i = 1'b1; ld_addr_i = a; ld_rd_i = rd; ld_funct3_i = f3;
    @(negedge clk);
    chk("ld_ready", ld_ready_o, 1);
    step();
    ld_valid_i = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("req_hold", mem_req_o, 1);
      chk("addr_hold", mem_addr_o, wa);
      step();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("req_gnt", mem_req_o, 1);
    chk("mem_addr", mem_addr_o, wa);
    chk("pend_rd", pend_rd_o, rd);
    step();
    mem_gnt_i = 1'b0;
    for (int i = 1; i < rv_dly; i++) step();
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < alu_n; i++) begin
      alu_wb_valid_i = 1'b1; alu_wb_rd_i = 5'd4; alu_wb_data_i = 32'h1234;
      exp_q.push_back({5'd4, 32'h1234});
      @(negedge clk);
      chk("stall_busy", busy_o, 1);
      step();
    end
    alu_wb_valid_i = 1'b0;
    if (rd != 5'd0) exp_q.push_back({rd, exp_data});
    @(negedge clk);
    chk("wb_cycle_write", reg_write_o, (rd != 5'd0));
    step();
    @(negedge clk);
    chk("busy_after", busy_o, 0);
    chk("no_write_after", reg_write_o, 0);
    chk("one_txn", n_txn - txn0, 1);
    step();
  endtask

  task automatic err_load(input logic [31:0] a, input logic [2:0] f3, input string tag);
    int req0;
    req0 = n_req_cyc;
    ld_valid_i = 1'b1; ld_addr_i = a; ld_rd_i = 5'd3; ld_funct3_i = f3;
    step();
    ld_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, ld_err_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    step();
    @(negedge clk);
    chk({tag, "_err_pulse"}, ld_err_o, 0);
    chk({tag, "_no_req"}, n_req_cyc - req0, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    ld_valid_i = 1'b0; ld_addr_i = 32'd0; ld_rd_i = 5'd0; ld_funct3_i = 3'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    alu_wb_valid_i = 1'b0; alu_wb_rd_i = 5'd0; alu_wb_data_i = 32'd0;
    @(negedge clk);
    chk("rst_ready", ld_ready_o, 1);
    chk("rst_req", mem_req_o, 0);
    chk("rst_err", ld_err_o, 0);
    chk("rst_pend", pend_rd_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_write", reg_write_o, 0);
    step();
    rst = 1'b0;
    step();

    do_load(32'h103, 5'd5, 3'b000, 32'h80AABBCC, 0, 1, 0, 32'hFFFFFF80);
    do_load(32'h102, 5'd6, 3'b101, 32'h80AABBCC, 0, 1, 0, 32'h000080AA);
    do_load(32'h100, 5'd7, 3'b010, 32'h80AABBCC, 0, 1, 0, 32'h80AABBCC);
    do_load(32'h101, 5'd8, 3'b100, 32'h80AABBCC, 0, 1, 0, 32'h000000BB);
    do_load(32'h100, 5'd12, 3'b001, 32'h80AABBCC, 0, 1, 0, 32'hFFFFBBCC);
    err_load(32'h101, 3'b001, "lh_misaligned");
    err_load(32'h102, 3'b010, "lw_misaligned");
    err_load(32'h100, 3'b011, "bad_funct3");
    do_load(32'h204, 5'd13, 3'b010, 32'h11223344, 3, 2, 0, 32'h11223344);
    do_load(32'h300, 5'd9, 3'b010, 32'hCAFEF00D, 0, 1, 2, 32'hCAFEF00D);
    do_load(32'h300, 5'd0, 3'b010, 32'h55555555, 0, 1, 0, 32'h0);

    // timeout: eight silent WAIT cycles, then an error pulse and a dropped late rvalid
    ld_valid_i = 1'b1; ld_addr_i = 32'h400; ld_rd_i = 5'd10; ld_funct3_i = 3'b010;
    step();
    ld_valid_i = 1'b0; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_wait_busy", busy_o, 1);
      chk("to_wait_err", ld_err_o, 0);
      step();
    end
    @(negedge clk);
    chk("to_err", ld_err_o, 1);
    chk("to_idle", busy_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
    step();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("to_late_rvalid", reg_write_o, 0);
    chk("to_late_busy", busy_o, 0);
    step();

    // reset in WAIT, then a stale rvalid
    ld_valid_i = 1'b1; ld_addr_i = 32'h500; ld_rd_i = 5'd11; ld_funct3_i = 3'b010;
    step();
    ld_valid_i = 1'b0; mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    step();
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99999999;
    step();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rst_stale_write", reg_write_o, 0);
    chk("rst_stale_busy", busy_o, 0);
    step();
    do_load(32'h502, 5'd14, 3'b001, 32'h8001FFFF, 1, 1, 0, 32'hFFFF8001);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
